// File: rtl/core_loader_pkg.sv
// Shared core package: loader sequencing states and the small byte-level
// typedefs used by the instruction loader and its counter.
package core_loader_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } loader_state_e;

    // Number of bytes carried by one instruction word.
    function automatic int bytes_per_word(input int data_w);
        return data_w / BYTE_W;
    endfunction

    // Width of a byte-lane index; never narrower than one bit.
    function automatic int lane_idx_w(input int data_w);
        int n;
        n = data_w / BYTE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_loader_cycle_counter.sv
// Run-cycle down-counter. Loaded with the requested cycle count, decremented
// while enabled, and stopped at zero; zero is the terminal-count flag.
module cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a load wins over a decrement; never underflow past zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/core_loader.sv
// Instruction loader: pulls a word stream, writes it byte-by-byte into the
// core's instruction memory, then releases the core from reset for a fixed
// number of cycles and reports completion.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; core held in reset
// LOAD  | s_ready high, waiting for the next program word
// WRITE | one byte of the latched word per cycle, little-endian
// RUN   | core out of reset, run-cycle counter decrementing
// DONE  | one cycle; done set, core back in reset, then IDLE
module core_loader
    import core_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,

    input  logic              start,
    input  logic [CNT_W-1:0]  run_cycles,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,

    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err_ovf
);

    localparam int BYTES = bytes_per_word(DATA_W);
    localparam int IDX_W = lane_idx_w(DATA_W);

    loader_state_e state_q, state_d;

    // Write pointer carries one extra bit: once it reaches 2^ADDR_W it sticks
    // there, which marks every further byte as out of range instead of wrapping.
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    byte_t             last_data_q, last_data_d;

    byte_t             cur_byte;
    logic              in_write;
    logic              byte_ok;
    logic              last_lane;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_zero;

    cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (run_cycles),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Select the byte lane currently being written.
    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_byte = word_q[8*k +: 8];
            end
        end
    end

    assign in_write  = (state_q == WRITE);
    assign byte_ok   = !wptr_q[ADDR_W];
    assign last_lane = (idx_q == IDX_W'(BYTES - 1));

    // Next-state and datapath updates for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        idx_d       = idx_q;
        word_d      = word_q;
        last_d      = last_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    done_d   = 1'b0;
                    ovf_d    = 1'b0;
                    wptr_d   = '0;
                    idx_d    = '0;
                    state_d  = LOAD;
                end
            end

            LOAD: begin
                if (s_valid) begin
                    word_d  = s_data;
                    last_d  = s_last;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end

            WRITE: begin
                if (byte_ok) begin
                    last_addr_d = wptr_q[ADDR_W-1:0];
                    last_data_d = cur_byte;
                    wptr_d      = wptr_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                idx_d = idx_q + 1'b1;
                if (last_lane) begin
                    if (!last_q) begin
                        state_d = LOAD;
                    end else if (cnt_zero) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // First RUN cycle is consumed here so the RUN phase
                        // lasts exactly run_cycles and exits on the zero flag.
                        cnt_en  = 1'b1;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (cnt_zero) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            last_q      <= last_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    // Memory port shows the live byte while writing, else the last byte written.
    assign mem_we    = in_write && byte_ok;
    assign mem_addr  = mem_we ? wptr_q[ADDR_W-1:0] : last_addr_q;
    assign mem_wdata = mem_we ? cur_byte : last_data_q;

    assign s_ready  = (state_q == LOAD);
    assign core_rst = (state_q != RUN);
    assign busy     = (state_q == LOAD) || (state_q == WRITE) || (state_q == RUN);
    assign done     = done_q;
    assign err_ovf  = ovf_q;

endmodule

// File: doc/core_loader.md
CORE_LOADER -- requirements
Module: core_loader

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, instruction word width in bits (multiple of 8, at least 8); ADDR_W, default 10, byte address width of the instruction memory; CNT_W, default 16, run-cycle counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock; rst_n, in, 1, asynchronous active-low reset.
REQ-003 The input word stream SHALL be: s_valid, in, 1, word available; s_ready, out, 1, word accepted; s_data, in, DATA_W, instruction word; s_last, in, 1, final word of the program.
REQ-004 The control ports SHALL be: start, in, 1, begin load; run_cycles, in, CNT_W, core cycles to run after load, sampled at start.
REQ-005 The instruction-memory port SHALL be: mem_we, out, 1, byte write strobe; mem_addr, out, ADDR_W, byte address; mem_wdata, out, 8, byte data.
REQ-006 The core-control and status ports SHALL be: core_rst, out, 1, active-high reset to the core; busy, out, 1, sequence in progress; done, out, 1, run complete (sticky); err_ovf, out, 1, program exceeded memory (sticky).

Function
REQ-007 The state machine SHALL have states IDLE, LOAD, WRITE, RUN and DONE.
REQ-008 IDLE: start=1 SHALL capture run_cycles, clear done and err_ovf, reset the write address to 0, and move to LOAD; start SHALL be ignored in every other state.
REQ-009 LOAD: s_ready SHALL be 1 and SHALL be 0 in every other state; when s_valid&&s_ready, the word and s_last SHALL be latched and the FSM SHALL move to WRITE.
REQ-010 WRITE: one byte SHALL be written per cycle for DATA_W/8 cycles, little-endian, with byte k = word[8k+7:8k] written to address base+k.
REQ-011 The address SHALL advance by 1 after each byte.
REQ-012 After the last byte of a word, the FSM SHALL return to LOAD, or go to RUN if the latched s_last=1.
REQ-013 Overflow: a byte whose address would exceed 2^ADDR_W-1 SHALL NOT be written (mem_we=0) and SHALL set err_ovf; the address SHALL NOT wrap; the remaining stream SHALL be consumed normally.
REQ-014 core_rst SHALL be 1 in IDLE, LOAD and WRITE, 0 throughout RUN, and 1 again in DONE.
REQ-015 RUN: the FSM SHALL stay in RUN for exactly run_cycles clock cycles, then enter DONE.
REQ-016 If run_cycles=0, the FSM SHALL go from the last WRITE byte directly to DONE, and core_rst SHALL never deassert.
REQ-017 DONE SHALL assert done for one cycle of state, then return to IDLE; done SHALL stay 1 until the next accepted start.
REQ-018 busy SHALL be 1 in LOAD, WRITE and RUN, and 0 in IDLE and DONE.
REQ-019 Latency: first mem_we SHALL occur in the cycle after the word handshake; a 3-word program with 4-byte words SHALL produce 12 mem_we cycles and 3 handshakes before RUN.
REQ-020 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-021 rst_n=0 SHALL asynchronously force IDLE with core_rst=1, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err_ovf=0 and counters cleared.
REQ-022 Reset asserted mid-LOAD, WRITE or RUN SHALL abort the sequence with no further memory writes, and core_rst SHALL be 1 from the reset edge.
REQ-023 After rst_n deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-024 The state enum (IDLE, LOAD, WRITE, RUN, DONE) SHALL reside in the shared core package alongside the existing core typedefs.
REQ-025 The run-cycle down-counter SHALL be a sub-module named cycle_counter, with load, enable and zero-flag ports; all other logic SHALL be in core_loader.

Verification
REQ-026 The bench SHALL stream 0x00100093, 0x00008133 and 0x002081B3 (s_last on the third word) with run_cycles=7 and no backpressure, then check: bytes 93 00 10 00 33 81 00 00 B3 81 20 00 at addresses 0-11; core_rst low for exactly 7 cycles; done=1; err_ovf=0.
REQ-027 The bench SHALL stream 2 words with s_valid low for 3 cycles between them, then check: s_ready stays high in LOAD, no mem_we during the gap, and addresses 0-7 are correct.
REQ-028 The bench SHALL run with ADDR_W=3 and a 3-word program, then check: bytes written only to addresses 0-7, err_ovf=1 after the 9th byte, no address wrap, and done still reached.
REQ-029 The bench SHALL run with run_cycles=0, then check: core_rst never falls and done=1 in the cycle after the last byte.
REQ-030 The bench SHALL assert rst_n=0 during the 3rd RUN cycle, then check: core_rst=1 and busy=0 immediately; done=0; and that start issued while busy is ignored.
